// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ producers.
// Optional macro TX_TIMEOUT_EN adds a WAIT_DONE watchdog that drops the byte.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_done,
   output logic                      busy,
   output logic [2:0]                cur_id,
   output logic                      timeout
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic                start_q, start_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                busy_q, busy_d;
   logic [2:0]          id_q, id_d;

   logic [DATA_W-1:0]   slot [NUM_REQ];
   logic                found;
   logic [PW-1:0]       win;
   logic [PW-1:0]       idx;

`ifdef TX_TIMEOUT_EN
   logic [15:0]         cnt_q, cnt_d;
   logic                tmo_q, tmo_d;
`else
   logic                unused_timeout_cyc;
   assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      assign slot[g] = req_data[g*DATA_W +: DATA_W];
   end

   // Round-robin search starting just after the last winner
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PW'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      start_d = 1'b0;
      data_d  = data_q;
      busy_d  = busy_q;
      id_d    = id_q;
`ifdef TX_TIMEOUT_EN
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d[win] = 1'b1;
               data_d     = slot[win];
               start_d    = 1'b1;
               busy_d     = 1'b1;
               ptr_d      = win;
               id_d       = 3'(win);
               state_d    = START;
            end
         end
         START: begin
            state_d = WAIT_DONE;
`ifdef TX_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT_DONE: begin
            if (tx_done) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
`ifdef TX_TIMEOUT_EN
            else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
               tmo_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NUM_REQ - 1);
         gnt_q   <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         id_q    <= 3'(NUM_REQ - 1);
`ifdef TX_TIMEOUT_EN
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         start_q <= start_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         id_q    <= id_d;
`ifdef TX_TIMEOUT_EN
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign tx_start = start_q;
   assign tx_data  = data_q;
   assign busy     = busy_q;
   assign cur_id   = id_q;
`ifdef TX_TIMEOUT_EN
   assign timeout  = tmo_q;
`else
   assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued
// when requests are driven and popped when tx_start appears.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int W = 8;
`ifdef TX_TIMEOUT_EN
   localparam int DONE_DLY = 10;
`else
   localparam int DONE_DLY = 20;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   gnt;
   logic           tx_start;
   logic [W-1:0]   tx_data;
   logic           tx_done;
   logic           busy;
   logic [2:0]     cur_id;
   logic           timeout;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int           id;
      logic [W-1:0] data;
   } exp_t;

   exp_t         sbq [$];
   exp_t         mon_e;
   logic [N-1:0] mon_g;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ(N),
      .DATA_W(W),
      .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .req_data(req_data),
      .gnt(gnt),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .tx_done(tx_done),
      .busy(busy),
      .cur_id(cur_id),
      .timeout(timeout)
   );

   // Scoreboard monitor: every tx_start must match the oldest expectation
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: gnt=%b id=%0d, required no grant",
                     gnt, cur_id);
         end else begin
            mon_e = sbq.pop_front();
            mon_g = '0;
            mon_g[mon_e.id] = 1'b1;
            if (gnt !== mon_g || tx_data !== mon_e.data ||
                cur_id !== 3'(mon_e.id)) begin
               errors++;
               $display("FAIL sb_grant: gnt=%b data=%h id=%0d, required gnt=%b data=%h id=%0d",
                        gnt, tx_data, cur_id, mon_g, mon_e.data, mon_e.id);
            end
         end
      end
      if (gnt !== '0 && !$onehot(gnt)) begin
         checks++;
         errors++;
         $display("FAIL gnt_onehot: gnt=%b, required one-hot", gnt);
      end
   end

   task automatic push_exp(input int id);
      exp_t e;
      e.id   = id;
      e.data = req_data[id*W +: W];
      sbq.push_back(e);
   endtask

   task automatic wait_start(input int max, output bit ok);
      int i;
      ok = 1'b0;
      i  = 0;
      while (!ok && i < max) begin
         @(negedge clk);
         i++;
         if (tx_start === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic complete(input int dly);
      repeat (dly - 1) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req      = '0;
      req_data = '0;
      tx_done  = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (gnt !== '0 || tx_start !== 1'b0 || tx_data !== '0) begin
         errors++;
         $display("FAIL reset_pulses: gnt=%b start=%b data=%h, required 0 0 00",
                  gnt, tx_start, tx_data);
      end
      checks++;
      if (busy !== 1'b0 || cur_id !== 3'd3 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b id=%0d tmo=%b, required 0 3 0",
                  busy, cur_id, timeout);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || gnt !== '0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b gnt=%b, required 0 0000", busy, gnt);
      end
   endtask

   task automatic test_single();
      req_data[7:0] = 8'hA5;
      req = 4'b0001;
      push_exp(0);
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001 || tx_start !== 1'b1 || tx_data !== 8'hA5 ||
          cur_id !== 3'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: gnt=%b st=%b data=%h id=%0d busy=%b, required 0001 1 a5 0 1",
                  gnt, tx_start, tx_data, cur_id, busy);
      end
      req = '0;
      req_data[7:0] = 8'h00;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (tx_data !== 8'hA5 || tx_start !== 1'b0 || gnt !== '0 ||
             busy !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: data=%h st=%b gnt=%b busy=%b, required a5 0 0000 1",
                     tx_data, tx_start, gnt, busy);
         end
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_fall: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_round_robin();
      bit           ok;
      int           id;
      logic [N-1:0] m;
      logic [W-1:0] b;
      do_reset();
      req_data = {8'h43, 8'h32, 8'h21, 8'h10};
      req = 4'b1111;
      for (int r = 0; r < 5; r++) push_exp(r % N);
      for (int r = 0; r < 5; r++) begin
         id = r % N;
         m = '0;
         m[id] = 1'b1;
         b = 8'h10 + 8'(8'h11 * id);
         wait_start(10, ok);
         checks++;
         if (!ok || gnt !== m || tx_data !== b) begin
            errors++;
            $display("FAIL rr_order[%0d]: seen=%b gnt=%b data=%h, required 1 %b %h",
                     r, ok, gnt, tx_data, m, b);
         end
         if (r == 4) req = '0;
         complete(DONE_DLY);
      end
   endtask

   task automatic test_ptr();
      bit ok;
      req = 4'b0010;
      push_exp(1);
      wait_start(10, ok);
      checks++;
      if (!ok || gnt !== 4'b0010) begin
         errors++;
         $display("FAIL ptr_setup: seen=%b gnt=%b, required 1 0010", ok, gnt);
      end
      req = 4'b0110;
      push_exp(2);
      push_exp(1);
      complete(5);
      wait_start(10, ok);
      checks++;
      if (!ok || gnt !== 4'b0100) begin
         errors++;
         $display("FAIL ptr_first: seen=%b gnt=%b, required 1 0100", ok, gnt);
      end
      complete(5);
      wait_start(10, ok);
      checks++;
      if (!ok || gnt !== 4'b0010) begin
         errors++;
         $display("FAIL ptr_second: seen=%b gnt=%b, required 1 0010", ok, gnt);
      end
      req = '0;
      complete(5);
   endtask

   task automatic test_idle_done_reset();
      bit ok;
      req = '0;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || gnt !== '0 || tx_start !== 1'b0 ||
             timeout !== 1'b0) begin
            errors++;
            $display("FAIL idle_done: busy=%b gnt=%b st=%b tmo=%b, required 0 0000 0 0",
                     busy, gnt, tx_start, timeout);
         end
      end
      req = 4'b0100;
      push_exp(2);
      wait_start(10, ok);
      req = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (!ok || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: seen=%b busy=%b, required 1 1", ok, busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || tx_start !== 1'b0 || cur_id !== 3'd3 ||
          gnt !== '0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b st=%b id=%0d gnt=%b, required 0 0 3 0000",
                  busy, tx_start, cur_id, gnt);
      end
      req = 4'b1111;
      push_exp(0);
      wait_start(10, ok);
      checks++;
      if (!ok || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL post_reset_prio: seen=%b gnt=%b, required 1 0001", ok, gnt);
      end
      req = '0;
      complete(5);
   endtask

   task automatic test_back_to_back();
      bit ok;
      req = 4'b0010;
      push_exp(1);
      wait_start(10, ok);
      req = '0;
      checks++;
      if (!ok || gnt !== 4'b0010) begin
         errors++;
         $display("FAIL b2b_first: seen=%b gnt=%b, required 1 0010", ok, gnt);
      end
      repeat (4) @(negedge clk);
      tx_done = 1'b1;
      req = 4'b0001;
      push_exp(0);
      @(negedge clk);
      tx_done = 1'b0;
      checks++;
      if (tx_start !== 1'b0 || gnt !== '0) begin
         errors++;
         $display("FAIL b2b_gap: st=%b gnt=%b, required 0 0000", tx_start, gnt);
      end
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b1 || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL b2b_second: st=%b gnt=%b, required 1 0001", tx_start, gnt);
      end
      req = '0;
      complete(5);
   endtask

`ifdef TX_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      do_reset();
      req = 4'b0011;
      push_exp(0);
      push_exp(1);
      wait_start(10, ok);
      checks++;
      if (!ok || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL tmo_first: seen=%b gnt=%b, required 1 0001", ok, gnt);
      end
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         checks++;
         if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early[%0d]: tmo=%b, required 0", k, timeout);
         end
      end
      @(negedge clk);
      checks++;
      if (timeout !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL tmo_pulse: tmo=%b busy=%b, required 1 0", timeout, busy);
      end
      @(negedge clk);
      checks++;
      if (timeout !== 1'b0 || tx_start !== 1'b1 || gnt !== 4'b0010) begin
         errors++;
         $display("FAIL tmo_next: tmo=%b st=%b gnt=%b, required 0 1 0010",
                  timeout, tx_start, gnt);
      end
      req = '0;
      complete(5);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ptr();
      test_idle_done_reset();
      test_back_to_back();
`ifdef TX_TIMEOUT_EN
      test_timeout();
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: pending=%0d, required 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t, required bench completion", $time);
      $fatal(1, "bench watchdog expired");
   end

endmodule
